// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset/power-down, qualifies the async LOCK input,
// retries failed locks and gates the system reset of the PLL-clocked domains.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3,
  parameter int SYNC_STAGES      = 2,
  localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pll_lock,
  input  logic           relock_req,
  output logic           pll_reset,
  output logic           pll_pwd,
  output logic           sys_rst,
  output logic           locked,
  output logic           fail,
  output logic [RTW-1:0] retry_cnt
);

  localparam int RCW = $clog2(RST_PULSE_CYC + 1);
  localparam int SCW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic [RCW-1:0]         rst_cnt, rst_cnt_n;
  logic [SCW-1:0]         stb_cnt, stb_cnt_n, stb_inc;
  logic [TCW-1:0]         tmo_cnt, tmo_cnt_n, tmo_inc;
  logic [RTW-1:0]         retry_n;

  // Synchroniser stage: pll_lock is asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_sync <= '0;
    else     lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s  = lock_sync[SYNC_STAGES-1];
  assign stb_inc = stb_cnt + SCW'(1);
  assign tmo_inc = tmo_cnt + TCW'(1);

  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    stb_cnt_n = stb_cnt;
    tmo_cnt_n = tmo_cnt;
    retry_n   = retry_cnt;
    case (state)
      ST_RESET: begin
        tmo_cnt_n = '0;
        stb_cnt_n = '0;
        if (rst_cnt == RCW'(RST_PULSE_CYC - 1)) begin
          state_n   = ST_WAIT;
          rst_cnt_n = '0;
        end else begin
          rst_cnt_n = rst_cnt + RCW'(1);
        end
      end
      // WAIT always holds stb_cnt at zero, so both states share one counting path
      ST_WAIT, ST_STABLE: begin
        tmo_cnt_n = tmo_inc;
        if (tmo_inc == TCW'(LOCK_TIMEOUT_CYC)) begin
          rst_cnt_n = '0;
          stb_cnt_n = '0;
          if (retry_cnt == RTW'(MAX_RETRY)) begin
            state_n = ST_FAIL;
          end else begin
            state_n = ST_RESET;
            retry_n = retry_cnt + RTW'(1);
          end
        end else if (!lock_s) begin
          state_n   = ST_WAIT;
          stb_cnt_n = '0;
        end else begin
          stb_cnt_n = stb_inc;
          state_n   = (stb_inc == SCW'(LOCK_STABLE_CYC)) ? ST_RUN : ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!lock_s || relock_req) begin
          state_n   = ST_RESET;
          rst_cnt_n = '0;
          retry_n   = '0;
        end
      end
      ST_FAIL: begin
        if (relock_req) begin
          state_n   = ST_RESET;
          rst_cnt_n = '0;
          retry_n   = '0;
        end
      end
      default: begin
        state_n   = ST_RESET;
        rst_cnt_n = '0;
        retry_n   = '0;
      end
    endcase
  end

  // State/output register stage: outputs decode state_n so they switch with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RESET;
      rst_cnt   <= '0;
      stb_cnt   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      pll_pwd   <= 1'b0;
      sys_rst   <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      rst_cnt   <= rst_cnt_n;
      stb_cnt   <= stb_cnt_n;
      tmo_cnt   <= tmo_cnt_n;
      retry_cnt <= retry_n;
      pll_reset <= (state_n == ST_RESET) || (state_n == ST_FAIL);
      pll_pwd   <= (state_n == ST_FAIL);
      sys_rst   <= (state_n != ST_RUN);
      locked    <= (state_n == ST_RUN);
      fail      <= (state_n == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters; each scenario
// follows on from the previous one's end state.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset, pll_pwd, sys_rst, locked, fail;
  logic [1:0] retry_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (4),
    .LOCK_STABLE_CYC (8),
    .LOCK_TIMEOUT_CYC(64),
    .MAX_RETRY       (2),
    .SYNC_STAGES     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .relock_req(relock_req),
    .pll_reset (pll_reset),
    .pll_pwd   (pll_pwd),
    .sys_rst   (sys_rst),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Packs {pll_reset, pll_pwd, sys_rst, locked, fail, retry_cnt}
  function automatic logic [31:0] outs();
    return {25'd0, pll_reset, pll_pwd, sys_rst, locked, fail, retry_cnt};
  endfunction

  initial begin
    // Reset state
    tick(2);
    chk("reset_outs", outs(), {25'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    rst = 1'b0;

    // 1 Nominal lock: RESET e1-e4, WAIT from e4, lock sampled from e10, RUN at e19
    tick(3);
    chk("nom_rst_pulse_e3", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("nom_rst_end_e4", {31'd0, pll_reset}, 32'd0);
    tick(5);
    pll_lock = 1'b1;
    tick(9);
    chk("nom_not_run_e18", {31'd0, locked}, 32'd0);
    tick(1);
    chk("nom_run_e19", outs(), {25'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});

    // 5 Lost lock: leaves RUN SYNC_STAGES+1 edges after the drop
    pll_lock = 1'b0;
    tick(2);
    chk("lost_still_run", {31'd0, locked}, 32'd1);
    tick(1);
    chk("lost_reset", outs(), {25'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tick(3);
    chk("lost_pulse_last", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("lost_pulse_end", {31'd0, pll_reset}, 32'd0);

    // 2 Glitch in STABLE, plus an ignored relock_req while in WAIT
    pll_lock = 1'b1;
    tick(1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(3);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(2);
    chk("glitch_back_wait", {30'd0, pll_reset, locked}, 32'd0);
    tick(7);
    chk("glitch_not_run_w15", {31'd0, locked}, 32'd0);
    tick(1);
    chk("glitch_run_w16", outs(), {25'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});

    // 3 Never locks: relock from RUN, then three 64-cycle timeouts
    relock_req = 1'b1;
    pll_lock   = 1'b0;
    tick(1);
    relock_req = 1'b0;
    chk("nl_relock_reset", outs(), {25'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tick(4);
    chk("nl_wait_r5", {31'd0, pll_reset}, 32'd0);
    tick(63);
    chk("nl_before_tmo1", outs(), {25'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tick(1);
    chk("nl_tmo1", outs(), {25'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tick(68);
    chk("nl_tmo2", outs(), {25'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2});
    tick(67);
    chk("nl_before_fail", {31'd0, fail}, 32'd0);
    tick(1);
    chk("nl_fail", outs(), {25'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2});
    tick(20);
    chk("nl_fail_sticky", {31'd0, fail}, 32'd1);

    // 4 FAIL recovery via relock_req
    relock_req = 1'b1;
    pll_lock   = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("rec_reset", outs(), {25'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tick(3);
    chk("rec_pulse_last", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("rec_pulse_end", {31'd0, pll_reset}, 32'd0);
    tick(7);
    chk("rec_not_run", {31'd0, locked}, 32'd0);
    tick(1);
    chk("rec_run", outs(), {25'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});

    // 6 Async rst in the middle of STABLE
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(7);
    chk("ar_in_stable", {29'd0, pll_reset, sys_rst, locked}, 32'b010);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_async_outs", {29'd0, pll_reset, sys_rst, locked}, 32'b110);
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("ar_pulse_last", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("ar_pulse_end", {31'd0, pll_reset}, 32'd0);
    tick(7);
    chk("ar_not_run", {31'd0, locked}, 32'd0);
    tick(1);
    chk("ar_run", outs(), {25'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
